data_ram_responder: RTL and testbench

//  Byte-addressed data memory that answers the CPU's MFA/MOC memory handshake.
//  It consumes DataSize, which is produced upstream from IR and the control-unit DSS field.
//  It serves byte, halfword, word and doubleword loads and stores with programmable wait states.

---
 rtl/data_ram_responder.sv | 188 ++++++++++++++++++
 tb/tb_data_ram_responder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/data_ram_responder.sv
// Byte-addressed big-endian data RAM answering the CPU MFA/MOC handshake with programmable wait states.
// Define MEM_ALIGN_FAULT_EN to add the AlignFault port and reject misaligned accesses instead of forcing alignment.
module data_ram_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MFA,
  input  logic        ReadWrite,
  input  logic [1:0]  DataSize,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MOC
`ifdef MEM_ALIGN_FAULT_EN
  ,
  output logic        AlignFault
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_DWRD = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT, S_HOLD} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            beat_q, beat_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            rw_q, rw_d;
  logic [1:0]      size_q, size_d;
  logic [31:0]     dout_q, dout_d;
  logic            moc_q, moc_d;
  logic            we_c;
  logic            misalign_c;
  logic [AW-1:0]   idx0_c, idx1_c, idx2_c, idx3_c;
  logic [31:0]     rdata_c;
  logic            unused_addr_c;

  logic [7:0]      mem_q [DEPTH];

  // Only the low address bits index the array; the rest wrap away.
  assign unused_addr_c = ^Address[31:AW];

`ifdef MEM_ALIGN_FAULT_EN
  logic fault_q, fault_d;
  assign misalign_c = (size_q == SZ_HALF) ? addr_q[0]
                    : (size_q[1] ? (addr_q[1:0] != 2'b00) : 1'b0);
  assign AlignFault = fault_q;
`else
  assign misalign_c = 1'b0;
`endif

  assign DataOut = dout_q;
  assign MOC     = moc_q;

  // Aligned byte lanes, most significant byte first.
  always_comb begin
    idx0_c = addr_q;
    if (size_q == SZ_HALF) idx0_c[0] = 1'b0;
    if (size_q[1])         idx0_c[1:0] = 2'b00;
    idx1_c = idx0_c + AW'(1);
    idx2_c = idx0_c + AW'(2);
    idx3_c = idx0_c + AW'(3);
  end

  always_comb begin
    case (size_q)
      SZ_BYTE: rdata_c = {24'b0, mem_q[idx0_c]};
      SZ_HALF: rdata_c = {16'b0, mem_q[idx0_c], mem_q[idx1_c]};
      default: rdata_c = {mem_q[idx0_c], mem_q[idx1_c], mem_q[idx2_c], mem_q[idx3_c]};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      beat_q  <= 1'b0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      size_q  <= '0;
      dout_q  <= '0;
      moc_q   <= 1'b0;
`ifdef MEM_ALIGN_FAULT_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      dout_q  <= dout_d;
      moc_q   <= moc_d;
`ifdef MEM_ALIGN_FAULT_EN
      fault_q <= fault_d;
`endif
    end
  end

  // Next-state and transaction context.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    size_d  = size_q;
    case (state_q)
      S_IDLE: begin
        if (MFA) begin
          state_d = S_WAIT;
          cnt_d   = CW'(WAIT_CYCLES);
          beat_d  = 1'b0;
          addr_d  = Address[AW-1:0];
          rw_d    = ReadWrite;
          size_d  = DataSize;
        end
      end
      S_WAIT: begin
        if (!MFA)              state_d = S_IDLE;
        else if (cnt_q == '0)  state_d = S_BEAT;
        else                   cnt_d   = cnt_q - CW'(1);
      end
      S_BEAT: begin
        if (!misalign_c && size_q == SZ_DWRD && !beat_q) begin
          state_d = S_WAIT;
          cnt_d   = CW'(WAIT_CYCLES);
          beat_d  = 1'b1;
          addr_d  = addr_q + AW'(4);
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        if (!MFA) state_d = S_IDLE;
      end
    endcase
  end

  // Beat outputs and write enable.
  always_comb begin
    moc_d  = 1'b0;
    dout_d = dout_q;
    we_c   = 1'b0;
`ifdef MEM_ALIGN_FAULT_EN
    fault_d = 1'b0;
`endif
    if (state_q == S_BEAT) begin
      moc_d = 1'b1;
      if (misalign_c) begin
`ifdef MEM_ALIGN_FAULT_EN
        fault_d = 1'b1;
`endif
      end else if (rw_q) begin
        dout_d = rdata_c;
      end else begin
        dout_d = '0;
        we_c   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we_c) begin
      case (size_q)
        SZ_BYTE: mem_q[idx0_c] <= DataIn[7:0];
        SZ_HALF: begin
          mem_q[idx0_c] <= DataIn[15:8];
          mem_q[idx1_c] <= DataIn[7:0];
        end
        default: begin
          mem_q[idx0_c] <= DataIn[31:24];
          mem_q[idx1_c] <= DataIn[23:16];
          mem_q[idx2_c] <= DataIn[15:8];
          mem_q[idx3_c] <= DataIn[7:0];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed self-checking bench for data_ram_responder (DEPTH=256, WAIT_CYCLES=2).
module tb_data_ram_responder;

  localparam int unsigned W = 2;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        MFA;
  logic        ReadWrite;
  logic [1:0]  DataSize;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        MOC;
`ifdef MEM_ALIGN_FAULT_EN
  logic        AlignFault;
  logic        flt_seen;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_b [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

  always #5 clk = ~clk;

  data_ram_responder #(.DEPTH(256), .WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .MFA       (MFA),
    .ReadWrite (ReadWrite),
    .DataSize  (DataSize),
    .Address   (Address),
    .DataIn    (DataIn),
    .DataOut   (DataOut),
`ifdef MEM_ALIGN_FAULT_EN
    .AlignFault(AlignFault),
`endif
    .MOC       (MOC)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one handshake; address/size are scrambled after acceptance to prove they are latched.
  task automatic access(input logic rw, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d0, input logic [31:0] d1, input int need,
                        output logic [31:0] rd0, output logic [31:0] rd1,
                        output int lat0, output int lat1);
    int n;
    int beats;
    rd0 = '0; rd1 = '0; lat0 = -1; lat1 = -1; n = 0; beats = 0;
    ReadWrite = rw; DataSize = sz; Address = a; DataIn = d0; MFA = 1'b1;
    @(posedge clk); #1;
    Address  = 32'hFFFF_FF81;
    DataSize = ~sz;
    while (beats < need && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (MOC) begin
        if (beats == 0) begin
          lat0 = n;
          rd0  = DataOut;
          DataIn = d1;
`ifdef MEM_ALIGN_FAULT_EN
          flt_seen = AlignFault;
`endif
        end else begin
          lat1 = n - lat0;
          rd1  = DataOut;
        end
        beats++;
      end
    end
    chk("moc_count", 32'(beats), 32'(need));
    MFA = 1'b0;
    @(posedge clk); #1;
    chk("moc_pulse", {31'b0, MOC}, 32'h0);
  endtask

  initial begin
    logic [31:0] r0, r1;
    int l0, l1, seen;
    reset = 1'b1; MFA = 1'b0; ReadWrite = 1'b0; DataSize = SZ_B; Address = '0; DataIn = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_moc", {31'b0, MOC}, 32'h0);
    chk("rst_dout", DataOut, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Word store then big-endian byte loads
    access(1'b0, SZ_W, 32'h10, 32'hDEADBEEF, 32'h0, 1, r0, r1, l0, l1);
    chk("st_w_lat", 32'(l0), 32'(W + 2));
    chk("st_w_dout", r0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      access(1'b1, SZ_B, 32'h10 + 32'(i), 32'h0, 32'h0, 1, r0, r1, l0, l1);
      chk("ld_b", r0, {24'b0, exp_b[i]});
    end

    // Halfword load latency and data hold
    access(1'b1, SZ_H, 32'h12, 32'h0, 32'h0, 1, r0, r1, l0, l1);
    chk("ld_h_lat", 32'(l0), 32'(W + 2));
    chk("ld_h", r0, 32'h0000BEEF);
    chk("dout_hold", DataOut, 32'h0000BEEF);

    // Doubleword store wrapping at DEPTH
    access(1'b0, SZ_D, 32'hFC, 32'h11223344, 32'h55667788, 2, r0, r1, l0, l1);
    chk("st_d_lat0", 32'(l0), 32'(W + 2));
    chk("st_d_lat1", 32'(l1), 32'(W + 2));
    access(1'b1, SZ_W, 32'hFC, 32'h0, 32'h0, 1, r0, r1, l0, l1);
    chk("ld_w_fc", r0, 32'h11223344);
    access(1'b1, SZ_W, 32'h00, 32'h0, 32'h0, 1, r0, r1, l0, l1);
    chk("ld_w_00", r0, 32'h55667788);
    access(1'b1, SZ_D, 32'hFC, 32'h0, 32'h0, 2, r0, r1, l0, l1);
    chk("ld_d_b0", r0, 32'h11223344);
    chk("ld_d_b1", r1, 32'h55667788);

    // Abort in WAIT writes nothing
    access(1'b0, SZ_W, 32'h40, 32'h0BADF00D, 32'h0, 1, r0, r1, l0, l1);
    ReadWrite = 1'b0; DataSize = SZ_W; Address = 32'h40; DataIn = 32'h12345678; MFA = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    MFA = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (MOC) seen++;
    end
    chk("abort_moc", 32'(seen), 32'h0);
    access(1'b1, SZ_W, 32'h40, 32'h0, 32'h0, 1, r0, r1, l0, l1);
    chk("abort_mem", r0, 32'h0BADF00D);

    // Reset during WAIT of a load
    ReadWrite = 1'b1; DataSize = SZ_W; Address = 32'h10; MFA = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; MFA = 1'b0;
    #1;
    chk("midrst_moc", {31'b0, MOC}, 32'h0);
    chk("midrst_dout", DataOut, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    access(1'b1, SZ_W, 32'h10, 32'h0, 32'h0, 1, r0, r1, l0, l1);
    chk("postrst_lat", 32'(l0), 32'(W + 2));
    chk("postrst_ld", r0, 32'hDEADBEEF);

    // Misaligned word store
`ifdef MEM_ALIGN_FAULT_EN
    access(1'b0, SZ_W, 32'h20, 32'h01020304, 32'h0, 1, r0, r1, l0, l1);
    access(1'b0, SZ_W, 32'h21, 32'hCAFEF00D, 32'h0, 1, r0, r1, l0, l1);
    chk("mis_fault", {31'b0, flt_seen}, 32'h1);
    chk("mis_dout", r0, 32'h0);
    access(1'b1, SZ_W, 32'h20, 32'h0, 32'h0, 1, r0, r1, l0, l1);
    chk("mis_mem", r0, 32'h01020304);
    chk("ok_fault", {31'b0, flt_seen}, 32'h0);
`else
    access(1'b0, SZ_W, 32'h21, 32'hCAFEF00D, 32'h0, 1, r0, r1, l0, l1);
    access(1'b1, SZ_W, 32'h20, 32'h0, 32'h0, 1, r0, r1, l0, l1);
    chk("mis_forced", r0, 32'hCAFEF00D);
    access(1'b1, SZ_H, 32'h23, 32'h0, 32'h0, 1, r0, r1, l0, l1);
    chk("mis_half", r0, 32'h0000F00D);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
